// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl
// ---------------------------------------------------------------------------
// Memory-mapped I/O block for the core's MW stage. It decodes the I/O-space
// register offsets, buffers UART traffic in TX/RX FIFOs and, optionally,
// keeps cycle / retired-instruction counters. Load data is registered, which
// gives it the same one-cycle latency as DMEM/BIOS.
//
// Build option: define MMIO_COUNTERS_EN to include the CYCLE/INSTR counters
// and CNTCLR. Without it, 0x10/0x14 read 0, 0x18 writes do nothing and
// inst_retire is ignored. UART/FIFO behaviour is the same in both builds.
//
// Parameters
//   FIFO_DEPTH  entries per FIFO (power of two, >= 2)
//   CNT_W       counter width (1..32), zero-extended on read
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/req_we   access this cycle / 1 = store
//   req_addr           byte offset addr[7:0], word aligned
//   req_wdata          store data
//   rdata              registered load data (valid the cycle after request)
//   inst_retire        one instruction retired this cycle
//   tx_data/tx_valid   TX FIFO head / TX FIFO not empty
//   tx_ready           transmitter accepts the head byte
//   rx_data/rx_valid   byte offered by the receiver
//   rx_ready           RX FIFO not full
//
// Handshake: a byte moves on a rising clk edge exactly when valid && ready
// are both high in the cycle before it; valid never depends on ready, and
// the offering side holds its byte while ready is low.
// ---------------------------------------------------------------------------
module mmio_uart_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   input  logic        inst_retire,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_RXDATA = 8'h04;
   localparam logic [7:0] ADDR_TXDATA = 8'h08;
   localparam logic [7:0] ADDR_LEVEL  = 8'h0C;
   localparam logic [7:0] ADDR_CYCLE  = 8'h10;
   localparam logic [7:0] ADDR_INSTR  = 8'h14;
   localparam logic [7:0] ADDR_CNTCLR = 8'h18;

   logic rd_req;
   logic wr_req;

   assign rd_req = req_valid && !req_we;
   assign wr_req = req_valid && req_we;

   // Only the low byte of store data is ever used.
   logic unused_wdata;
   assign unused_wdata = ^req_wdata[31:8];

   // ------------------------------------------------------------------ TX FIFO
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wp;
   logic [PW-1:0] tx_rp;
   logic [PW-1:0] tx_count;
   logic          tx_full;
   logic          tx_empty;
   logic          tx_push;
   logic          tx_pop;

   assign tx_count = tx_wp - tx_rp;
   assign tx_empty = (tx_wp == tx_rp);
   // Extra pointer bit distinguishes full (wrapped once more) from empty.
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_push  = wr_req && (req_addr == ADDR_TXDATA) && !tx_full;
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_valid = !tx_empty;
   // Stale memory contents are masked so tx_data reads 0 while empty.
   assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push && !rst) tx_mem[tx_wp[AW-1:0]] <= req_wdata[7:0];
   end

   // ------------------------------------------------------------------ RX FIFO
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] rx_wp;
   logic [PW-1:0] rx_rp;
   logic [PW-1:0] rx_count;
   logic          rx_full;
   logic          rx_empty;
   logic          rx_push;
   logic          rx_pop;
   logic [7:0]    rx_head;
   logic          rx_overflow;

   assign rx_count = rx_wp - rx_rp;
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid && rx_ready;
   // An RXDATA load on an empty FIFO returns 0 and leaves the pointers alone.
   assign rx_pop   = rd_req && (req_addr == ADDR_RXDATA) && !rx_empty;
   assign rx_head  = rx_mem[rx_rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push && !rst) rx_mem[rx_wp[AW-1:0]] <= rx_data;
   end

   // Sticky advisory flag: the receiver was refused a byte. A fresh refusal
   // in the same cycle as a STATUS write keeps the flag set, so no event is
   // lost to the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overflow <= 1'b0;
      end else if (rx_valid && rx_full) begin
         rx_overflow <= 1'b1;
      end else if (wr_req && (req_addr == ADDR_STATUS)) begin
         rx_overflow <= 1'b0;
      end
   end

   // ----------------------------------------------------------------- counters
   logic [31:0] cyc_ext;
   logic [31:0] ins_ext;

`ifdef MMIO_COUNTERS_EN
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] ins_cnt;
   logic             cnt_clr;

   assign cnt_clr = wr_req && (req_addr == ADDR_CNTCLR);

   // Clear has priority over the increment of the same cycle.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cyc_cnt <= '0;
         ins_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (inst_retire) ins_cnt <= ins_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      cyc_ext = '0;
      ins_ext = '0;
      cyc_ext[CNT_W-1:0] = cyc_cnt;
      ins_ext[CNT_W-1:0] = ins_cnt;
   end
`else
   logic unused_inst;
   assign unused_inst = inst_retire;
   assign cyc_ext     = '0;
   assign ins_ext     = '0;
`endif

   // ------------------------------------------------------------- read path
   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (req_addr)
         ADDR_STATUS: rd_mux = {29'b0, rx_overflow, !rx_empty, !tx_full};
         ADDR_RXDATA: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_head};
         ADDR_LEVEL:  rd_mux = {16'b0, 8'(tx_count), 8'(rx_count)};
         ADDR_CYCLE:  rd_mux = cyc_ext;
         ADDR_INSTR:  rd_mux = ins_ext;
         default:     rd_mux = '0;
      endcase
   end

   // rdata only changes on a load; stores and idle cycles hold it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd_req) begin
         rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
`timescale 1ns/1ps
module tb_mmio_uart_ctrl;

   localparam int DEPTH = 8;

   // ----------------------------------------------------- clock / reset / dut
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        inst_retire;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   always #5 clk = ~clk;

   mmio_uart_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rdata(rdata), .inst_retire(inst_retire),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

`ifdef MMIO_COUNTERS_EN
   logic        w4_req_valid;
   logic [31:0] w4_rdata;
   logic [7:0]  unused_w4_tx_data;
   logic        unused_w4_tx_valid;
   logic        unused_w4_rx_ready;

   mmio_uart_ctrl #(.FIFO_DEPTH(2), .CNT_W(4)) u_dut_w4 (
      .clk(clk), .rst(rst),
      .req_valid(w4_req_valid), .req_we(1'b0), .req_addr(8'h10), .req_wdata(32'h0),
      .rdata(w4_rdata), .inst_retire(1'b0),
      .tx_data(unused_w4_tx_data), .tx_valid(unused_w4_tx_valid), .tx_ready(1'b0),
      .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(unused_w4_rx_ready)
   );
`endif

   // --------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ----------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_req();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = a;
      tick();
      idle_req();
      check(nm, rdata, exp);
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = a;
      req_wdata = d;
      tick();
      idle_req();
   endtask

   task automatic rx_send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      check("rx_ready_accept", {31'b0, rx_ready}, 32'h1);
      tick();
      rx_valid = 1'b0;
   endtask

   // ------------------------------------------------------ vector table
   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic we, input logic [7:0] a, input logic [31:0] wd,
                          input logic chk, input logic [31:0] e, input string nm);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.chk = chk; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   // ------------------------------------------------ reference model (queues)
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   logic        m_ovf;
   logic [31:0] m_rdata;
   logic [31:0] m_cyc;
   logic [31:0] m_ins;

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [31:0] v;
      v = 32'h0;
      case (a)
         8'h00: v = {29'b0, m_ovf, rx_q.size() != 0, tx_q.size() != DEPTH};
         8'h04: v = (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
         8'h0C: v = {16'b0, 8'(tx_q.size()), 8'(rx_q.size())};
`ifdef MMIO_COUNTERS_EN
         8'h10: v = m_cyc;
         8'h14: v = m_ins;
`endif
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic model_cycle();
      logic tx_full_now, rx_full_now, do_tx_pop, do_tx_push, do_rx_pop, do_rx_push, clr;
      tx_full_now = (tx_q.size() == DEPTH);
      rx_full_now = (rx_q.size() == DEPTH);
      do_tx_pop   = (tx_q.size() != 0) && tx_ready;
      do_tx_push  = req_valid && req_we && (req_addr == 8'h08) && !tx_full_now;
      do_rx_pop   = req_valid && !req_we && (req_addr == 8'h04) && (rx_q.size() != 0);
      do_rx_push  = rx_valid && !rx_full_now;
      clr         = req_valid && req_we && (req_addr == 8'h18);
      if (req_valid && !req_we) m_rdata = model_read(req_addr);
      m_ovf = (rx_valid && rx_full_now) || (m_ovf && !(req_valid && req_we && req_addr == 8'h00));
      if (do_tx_pop)  void'(tx_q.pop_front());
      if (do_tx_push) tx_q.push_back(req_wdata[7:0]);
      if (do_rx_pop)  void'(rx_q.pop_front());
      if (do_rx_push) rx_q.push_back(rx_data);
      if (clr) begin
         m_cyc = 0;
         m_ins = 0;
      end else begin
         m_cyc = m_cyc + 1;
         m_ins = m_ins + {31'b0, inst_retire};
      end
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1; idle_req();
      inst_retire = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
`ifdef MMIO_COUNTERS_EN
      w4_req_valid = 1'b0;
`endif
      do_reset();

      // reset state
      check("rdata_reset", rdata, 32'h0);
      check("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
      check("tx_data_reset", {24'b0, tx_data}, 32'h0);
      check("rx_ready_reset", {31'b0, rx_ready}, 32'h1);

      // table: register reads, TX fill to full plus one dropped byte
      add_vec(0, 8'h00, 0, 1, 32'h1, "status_reset");
      add_vec(0, 8'h0C, 0, 1, 32'h0, "level_reset");
      add_vec(0, 8'h04, 0, 1, 32'h0, "rxdata_empty_reset");
      add_vec(0, 8'h1C, 0, 1, 32'h0, "unmapped_read");
      for (int i = 0; i < 8; i++) add_vec(1, 8'h08, 32'h41 + i, 0, 0, "");
      add_vec(0, 8'h0C, 0, 1, 32'h800, "level_tx_full");
      add_vec(1, 8'h08, 32'h49, 0, 0, "");
      add_vec(0, 8'h0C, 0, 1, 32'h800, "level_tx_drop");
      add_vec(0, 8'h00, 0, 1, 32'h0, "status_tx_full");
`ifndef MMIO_COUNTERS_EN
      add_vec(0, 8'h10, 0, 1, 32'h0, "cycle_disabled");
      add_vec(1, 8'h18, 32'hFFFF_FFFF, 0, 0, "");
      add_vec(0, 8'h14, 0, 1, 32'h0, "instr_disabled");
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         req_valid = 1'b1;
         req_we    = vecs[i].we;
         req_addr  = vecs[i].addr;
         req_wdata = vecs[i].wdata;
         tick();
         idle_req();
         if (vecs[i].chk) check(vecs[i].name, rdata, vecs[i].exp);
      end

      // RX fill to full with one more byte held (TX still full, so STATUS[0]=0)
      for (int i = 0; i < 8; i++) rx_send(8'(8'h10 + i));
      rx_data = 8'h18; rx_valid = 1'b1;
      check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
      tick();
      tick();
      check("rx_ready_held", {31'b0, rx_ready}, 32'h0);
      bus_read(8'h00, 32'h6, "status_overflow");
      rx_valid = 1'b0;
      bus_read(8'h04, 32'h10, "rxdata_first");
      bus_read(8'h0C, 32'h807, "level_after_pop");
      bus_write(8'h00, 32'h0);
      bus_read(8'h00, 32'h2, "status_ovf_cleared");

      // TX drain: 0x41..0x48 on consecutive cycles, 0x49 never appears
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("tx_valid_drain", {31'b0, tx_valid}, 32'h1);
         check("tx_data_drain", {24'b0, tx_data}, 32'h41 + i);
         tick();
      end
      check("tx_valid_empty", {31'b0, tx_valid}, 32'h0);
      check("tx_data_empty", {24'b0, tx_data}, 32'h0);
      tx_ready = 1'b0;

      // RX drain, then read on empty
      for (int i = 1; i < 8; i++) bus_read(8'h04, 32'h10 + i, "rxdata_drain");
      bus_read(8'h04, 32'h0, "rxdata_empty");
      bus_read(8'h0C, 32'h0, "level_empty");

      // same-cycle RX push and RXDATA pop at count 3
      rx_send(8'hA0); rx_send(8'hA1); rx_send(8'hA2);
      bus_read(8'h0C, 32'h3, "level_three");
      rx_data = 8'hA3; rx_valid = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h04;
      tick();
      idle_req(); rx_valid = 1'b0;
      check("rxdata_pushpop", rdata, 32'hA0);
      bus_read(8'h0C, 32'h3, "level_pushpop");
      bus_read(8'h04, 32'hA1, "rxdata_order1");
      bus_read(8'h04, 32'hA2, "rxdata_order2");
      bus_read(8'h04, 32'hA3, "rxdata_order3");

      // reset mid-operation, with a store coincident with rst
      bus_write(8'h08, 32'h55);
      bus_write(8'h08, 32'h66);
      rx_send(8'h77); rx_send(8'h88);
      bus_read(8'h0C, 32'h202, "level_before_rst");
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h08; req_wdata = 32'h99;
      tick();
      idle_req();
      tick();
      rst = 1'b0;
      check("rdata_after_rst", rdata, 32'h0);
      check("tx_valid_after_rst", {31'b0, tx_valid}, 32'h0);
      check("rx_ready_after_rst", {31'b0, rx_ready}, 32'h1);
      bus_read(8'h0C, 32'h0, "level_after_rst");
      bus_read(8'h00, 32'h1, "status_after_rst");

`ifdef MMIO_COUNTERS_EN
      // counters: 100 cycles, 40 retire pulses; CNT_W=4 instance wraps 15->0
      do_reset();
      for (int k = 0; k < 100; k++) begin
         inst_retire  = ((k % 5) < 2);
         w4_req_valid = (k == 15) || (k == 16);
         tick();
         if (k == 15) check("w4_cycle_15", w4_rdata, 32'd15);
         if (k == 16) check("w4_cycle_wrap", w4_rdata, 32'd0);
      end
      inst_retire = 1'b0; w4_req_valid = 1'b0;
      bus_read(8'h10, 32'd100, "cycle_100");
      bus_read(8'h14, 32'd40, "instr_40");
      inst_retire = 1'b1; bus_write(8'h18, 32'h0); inst_retire = 1'b0;
      bus_read(8'h10, 32'd0, "cycle_cleared");
      inst_retire = 1'b1; bus_write(8'h18, 32'h0); inst_retire = 1'b0;
      bus_read(8'h14, 32'd0, "instr_cleared");
`endif

      // randomized traffic against the queue model
      do_reset();
      tx_q.delete(); rx_q.delete();
      m_ovf = 1'b0; m_rdata = 32'h0; m_cyc = 32'h0; m_ins = 32'h0;
      for (int n = 0; n < 800; n++) begin
         int op;
         int txp;
         txp = (n < 400) ? 20 : 70;
         op  = $urandom_range(0, 12);
         idle_req();
         case (op)
            2:       begin req_valid = 1; req_addr = 8'h00; end
            3, 4:    begin req_valid = 1; req_addr = 8'h04; end
            5:       begin req_valid = 1; req_addr = 8'h0C; end
            6, 7:    begin req_valid = 1; req_we = 1; req_addr = 8'h08; req_wdata = $urandom; end
            8:       begin req_valid = 1; req_we = 1; req_addr = 8'h00; end
            9:       begin req_valid = 1; req_addr = ($urandom_range(0, 1) != 0) ? 8'h10 : 8'h14; end
            10:      begin req_valid = 1; req_we = 1; req_addr = 8'h18; end
            11:      begin req_valid = 1; req_addr = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h20; end
            12:      begin req_valid = 1; req_we = 1; req_addr = 8'h04; req_wdata = $urandom; end
            default: ;
         endcase
         tx_ready    = ($urandom_range(0, 99) < txp);
         rx_valid    = ($urandom_range(0, 1) != 0);
         rx_data     = 8'($urandom);
         inst_retire = ($urandom_range(0, 1) != 0);
         model_cycle();
         tick();
         check("rand_rdata", rdata, m_rdata);
         check("rand_tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
         check("rand_tx_data", {24'b0, tx_data}, (tx_q.size() != 0) ? {24'b0, tx_q[0]} : 32'h0);
         check("rand_rx_ready", {31'b0, rx_ready}, {31'b0, rx_q.size() != DEPTH});
      end
      idle_req();
      rx_valid = 1'b0; tx_ready = 1'b0; inst_retire = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Memory-mapped I/O controller for the RISC-V core's memory/writeback stage. It decodes accesses to the 0x8xxx_xxxx I/O space and buffers UART traffic in parametrised TX/RX FIFOs. It also provides cycle and retired-instruction counters. Read data has the same one-cycle latency as DMEM/BIOS, so the core's writeback mux treats it as one more synchronous memory.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: entries per FIFO. Must be a power of two, ≥2.
- `CNT_W`, 32: counter width, 1..32. Counter reads are zero-extended to 32 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `req_valid`  in  1  access this cycle. Only asserted for addresses with addr[31:28]==4'h8.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  8  byte offset, addr[7:0]. Word-aligned.
- `req_wdata`  in  32  store data.
- `rdata`  out  32  load data, registered. Valid the cycle after the request.
- `inst_retire`  in  1  one instruction retired this cycle (non-bubble in MW).
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  TX FIFO not empty.
- `tx_ready`  in  1  transmitter accepts.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  receiver has a byte.
- `rx_ready`  out  1  RX FIFO not full.

## Operation
Register map (offsets). Unmapped offsets read 0; writes to them are ignored.
- 0x00 STATUS, RO:
  - [0] TX FIFO not full.
  - [1] RX FIFO not empty.
  - [2] rx_overflow, sticky.
  - Any write to 0x00 clears rx_overflow.
- 0x04 RXDATA, RO: returns {24'b0, head byte} and pops the RX FIFO. If the FIFO is empty, returns 0 and does not pop.
- 0x08 TXDATA, WO: pushes req_wdata[7:0]. If the TX FIFO is full, the byte is dropped and no state changes.
- 0x0C LEVEL, RO: tx_count in [15:8], rx_count in [7:0]. Counts are zero-extended and range 0..FIFO_DEPTH.
- 0x10 CYCLE, RO: cycles since reset or the last counter clear.
- 0x14 INSTR, RO: inst_retire pulses since reset or the last counter clear.
- 0x18 CNTCLR, WO: any write zeroes both counters.

FIFOs:
- Circular buffers with log2(FIFO_DEPTH)+1-bit read/write pointers. Full = MSBs differ and low bits are equal.
- TX side: head is tx_data. A pop occurs when tx_valid && tx_ready.
- RX side: a push occurs when rx_valid && rx_ready.
- rx_overflow sets when rx_valid is high while the RX FIFO is full. The receiver then holds the byte (ready low), so the flag is advisory only; no data is lost.
- Simultaneous push and pop on one FIFO:
  - Not full: both happen and the count is unchanged.
  - Full: the pop happens and the push is refused that cycle (ready was low).
  - Empty: the push happens and the pop does not (valid was low).

Counters:
- Each increments by 1 per qualifying cycle and wraps modulo 2^CNT_W.
- A CNTCLR write in the same cycle as an increment: clear wins, and both counters read 0 next cycle.

## Timing
- Load: rdata is registered at the clk edge ending the request cycle.
  - CYCLE value reported = count at the request cycle.
  - An RXDATA pop is effective at that same edge.
- Store: state updates at the clk edge ending the request cycle. The TX byte is visible on tx_data/tx_valid the next cycle at the earliest.
- req_valid low: rdata holds its previous value. No side effects.
- Reset values: rdata=0, tx_valid=0, tx_data=0, rx_ready=1. Both FIFOs are empty, rx_overflow=0, both counters=0.
- Reset mid-operation: all buffered bytes are discarded. A request coincident with rst is ignored.
- Counters start counting in the first cycle after rst deasserts.

## Configuration
- `MMIO_COUNTERS_EN` defined: CYCLE, INSTR and CNTCLR are implemented as above.
- `MMIO_COUNTERS_EN` undefined:
  - Counter registers and logic are removed.
  - 0x10 and 0x14 read 0; 0x18 writes are ignored.
  - inst_retire is unused.
  - The UART and FIFO behaviour is identical in both builds.

## Test plan
- Reset, then read 0x00 → 0x00000001. Read 0x0C → 0x00000000. tx_valid=0, rx_ready=1.
- FIFO_DEPTH=8, tx_ready=0; write 0x41..0x49 (9 bytes) to 0x08 → LEVEL=0x00000800 and STATUS[0]=0. Raise tx_ready → tx_data emits 0x41..0x48 on consecutive cycles; 0x49 never appears.
- Drive rx bytes 0x10..0x17 plus one more with rx_valid held → rx_ready=0 after 8 bytes and STATUS=0x6. Read 0x04 → 0x10 next cycle, LEVEL[7:0]=7. Write 0x00 → STATUS[2]=0.
- Read 0x04 with the RX FIFO empty → rdata=0 and LEVEL unchanged.
- Same-cycle RX push and RXDATA pop with rx_count=3 → count stays 3, and the bytes come out in FIFO order.
- Counters (`MMIO_COUNTERS_EN` defined):
  - 100 cycles after reset, 40 inst_retire pulses → CYCLE read returns 100, INSTR read returns 40.
  - Write 0x18 with inst_retire high → both counters read 0 the next cycle.
  - CNT_W=4: CYCLE wraps 15 → 0.
